vga_sprite_anim_module: RTL and testbench

- Parametrised sprite animator for the VGA pipeline. Sits between the sync generator and the RGB565 output.
- Draws one monochrome glyph sequence, read from a synchronous glyph ROM, at a runtime position with integer scaling.
- Steps through animation frames only on frame boundaries. Supports loop, ping-pong and one-shot playback with a start/done handshake.

---
 rtl/vga_sprite_anim_module_if.sv | 26 ++
 rtl/vga_sprite_anim_module.sv | 192 +++++++++++++++++++
 tb/tb_vga_sprite_anim_module.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sprite_anim_module_if.sv
// Pixel/ROM bus between the sync generator side and the sprite animator.
// master: sync generator + glyph ROM side; slave: vga_sprite_anim_module.
interface vga_sprite_anim_module_if #(
  parameter int GLYPH_W = 16,
  parameter int ADDR_W  = 7
);
  logic               Ready_Sig;
  logic               Frame_Sig;
  logic [11:0]        Column_Addr_Sig;
  logic [11:0]        Row_Addr_Sig;
  logic [ADDR_W-1:0]  rom_addr;
  logic [GLYPH_W-1:0] rom_data;
  logic [4:0]         Red_Sig;
  logic [5:0]         Green_Sig;
  logic [4:0]         Blue_Sig;

  modport master (
    output Ready_Sig, Frame_Sig, Column_Addr_Sig, Row_Addr_Sig, rom_data,
    input  rom_addr, Red_Sig, Green_Sig, Blue_Sig
  );

  modport slave (
    input  Ready_Sig, Frame_Sig, Column_Addr_Sig, Row_Addr_Sig, rom_data,
    output rom_addr, Red_Sig, Green_Sig, Blue_Sig
  );
endinterface

// File: rtl/vga_sprite_anim_module.sv
// Sprite animator: draws one scaled monochrome glyph from a glyph ROM at a
// frame-latched position and steps through animation frames on frame
// boundaries (loop / ping-pong / one-shot / pause).
// Two-stage pixel pipeline: stage 1 issues rom_addr, stage 2 consumes
// rom_data in the following cycle and registers RGB565.
// Optional build macro SPRITE_MIRROR_EN adds mirror_h (horizontal flip).
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | after reset, frame 0 shown, waiting for start
// ST_RUN_FWD  | stepping upward through frames
// ST_RUN_BWD  | ping-pong return leg, stepping downward
// ST_DONE     | one-shot finished, last frame held, done = 1
module vga_sprite_anim_module #(
  parameter int GLYPH_W     = 16,
  parameter int GLYPH_H     = 16,
  parameter int NUM_FRAMES  = 6,
  parameter int HOLD_FRAMES = 60,
  parameter int SCALE_LOG2  = 0,
  parameter int ADDR_W      = 7,
  localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                    vga_clk,
  input  logic                    rst,
  vga_sprite_anim_module_if.slave vga,
  input  logic [11:0]             pos_x,
  input  logic [11:0]             pos_y,
  input  logic [15:0]             fg_color,
  input  logic [15:0]             bg_color,
  input  logic [1:0]              anim_mode,
  input  logic                    start,
`ifdef SPRITE_MIRROR_EN
  input  logic                    mirror_h,
`endif
  output logic                    done,
  output logic [FRAME_W-1:0]      cur_frame
);

  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int BIT_W  = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

  localparam logic [12:0]        BOX_W     = 13'(GLYPH_W << SCALE_LOG2);
  localparam logic [12:0]        BOX_H     = 13'(GLYPH_H << SCALE_LOG2);
  localparam logic [FRAME_W-1:0] LAST_IDX  = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [BIT_W-1:0]   BIT_MSB   = BIT_W'(GLYPH_W - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN_FWD = 2'd1;
  localparam logic [1:0] ST_RUN_BWD = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [1:0] MODE_LOOP    = 2'd0;
  localparam logic [1:0] MODE_PING    = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;
  localparam logic [1:0] MODE_PAUSE   = 2'd3;

  logic [1:0]         state;
  logic [FRAME_W-1:0] frame_idx;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [11:0]        lat_x;
  logic [11:0]        lat_y;
  logic               lat_mirror;
  logic               running;

  // position is only taken at frame boundaries so the sprite never tears
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      lat_x <= '0;
      lat_y <= '0;
    end else if (vga.Frame_Sig) begin
      lat_x <= pos_x;
      lat_y <= pos_y;
    end
  end

`ifdef SPRITE_MIRROR_EN
  // mirror flag follows the same frame-boundary latch as the position
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst)                lat_mirror <= 1'b0;
    else if (vga.Frame_Sig) lat_mirror <= mirror_h;
  end
`else
  assign lat_mirror = 1'b0;
`endif

  assign running   = (state == ST_RUN_FWD) || (state == ST_RUN_BWD);
  assign cur_frame = frame_idx;

  // animation sequencer: start acts immediately, everything else on Frame_Sig
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      frame_idx <= '0;
      hold_cnt  <= '0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= ST_RUN_FWD;
      frame_idx <= '0;
      hold_cnt  <= '0;
      done      <= 1'b0;
    end else if (vga.Frame_Sig && running && (anim_mode != MODE_PAUSE)) begin
      if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
        if (state == ST_RUN_FWD) begin
          if (frame_idx != LAST_IDX) begin
            frame_idx <= frame_idx + 1'b1;
          end else begin
            case (anim_mode)
              MODE_PING: begin
                state     <= ST_RUN_BWD;
                frame_idx <= (NUM_FRAMES > 1) ? frame_idx - 1'b1 : '0;
              end
              MODE_ONESHOT: begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
              default: frame_idx <= '0;
            endcase
          end
        end else begin
          // a mode change away from ping-pong resumes forward from here
          if (anim_mode != MODE_PING) begin
            state <= ST_RUN_FWD;
          end else if (frame_idx == '0) begin
            state     <= ST_RUN_FWD;
            frame_idx <= (NUM_FRAMES > 1) ? FRAME_W'(1) : '0;
          end else begin
            frame_idx <= frame_idx - 1'b1;
          end
        end
      end
    end
  end

  logic [12:0]       col_e, row_e, x_lo, y_lo;
  logic [11:0]       dx, dy, gx, gy;
  logic              in_box;
  logic [ADDR_W-1:0] addr_d;
  logic [BIT_W-1:0]  bit_d;

  // stage 1 decode; 13-bit compares let the box run past column/row 4095
  always_comb begin
    col_e  = {1'b0, vga.Column_Addr_Sig};
    row_e  = {1'b0, vga.Row_Addr_Sig};
    x_lo   = {1'b0, lat_x};
    y_lo   = {1'b0, lat_y};
    in_box = vga.Ready_Sig &&
             (col_e >= x_lo) && (col_e < x_lo + BOX_W) &&
             (row_e >= y_lo) && (row_e < y_lo + BOX_H);
    dx     = vga.Column_Addr_Sig - lat_x;
    dy     = vga.Row_Addr_Sig - lat_y;
    gx     = dx >> SCALE_LOG2;
    gy     = dy >> SCALE_LOG2;
    addr_d = ADDR_W'(32'(frame_idx) * GLYPH_H) + ADDR_W'(gy);
    bit_d  = lat_mirror ? BIT_W'(gx) : BIT_MSB - BIT_W'(gx);
  end

  logic [BIT_W-1:0] bit_q;
  logic             in_box_q;
  logic             ready_q;

  // stage 1 registers: ROM address plus the qualifiers that travel with it
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      vga.rom_addr <= '0;
      bit_q        <= '0;
      in_box_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      vga.rom_addr <= in_box ? addr_d : '0;
      bit_q        <= in_box ? bit_d : '0;
      in_box_q     <= in_box;
      ready_q      <= vga.Ready_Sig;
    end
  end

  logic [15:0] rgb_q;

  // stage 2: colour select from the glyph bit, black outside the sprite box
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst)            rgb_q <= '0;
    else if (!ready_q)  rgb_q <= '0;
    else if (in_box_q)  rgb_q <= vga.rom_data[bit_q] ? fg_color : bg_color;
    else                rgb_q <= '0;
  end

  assign {vga.Red_Sig, vga.Green_Sig, vga.Blue_Sig} = rgb_q;

endmodule

// File: tb/tb_vga_sprite_anim_module.sv
// Bench for vga_sprite_anim_module: three instances with different
// NUM_FRAMES / HOLD_FRAMES / SCALE_LOG2 share one stimulus stream and are
// compared against a frame-count based reference model.
module tb_vga_sprite_anim_module;
  logic        vga_clk = 1'b0;
  logic        rst;
  logic        ready, frame, start, mirror;
  logic [11:0] col, row, pos_x, pos_y;
  logic [15:0] fg, bg;
  logic [1:0]  mode;
  logic [15:0] rom [128];
  logic [15:0] rgb_o [3];
  logic [6:0]  addr_o [3];
  logic [2:0]  cur_o [3];
  logic [1:0]  cf1;
  logic        done_o [3];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: shared latch state and count of counted frame pulses
  int m_frames, m_px, m_py, m_mode;
  bit m_running, m_mir;

  always #5 vga_clk = ~vga_clk;

  vga_sprite_anim_module_if #(.GLYPH_W(16), .ADDR_W(7)) vga0 ();
  vga_sprite_anim_module_if #(.GLYPH_W(16), .ADDR_W(6)) vga1 ();
  vga_sprite_anim_module_if #(.GLYPH_W(16), .ADDR_W(7)) vga2 ();

  assign vga0.Ready_Sig = ready;  assign vga1.Ready_Sig = ready;  assign vga2.Ready_Sig = ready;
  assign vga0.Frame_Sig = frame;  assign vga1.Frame_Sig = frame;  assign vga2.Frame_Sig = frame;
  assign vga0.Column_Addr_Sig = col;  assign vga1.Column_Addr_Sig = col;  assign vga2.Column_Addr_Sig = col;
  assign vga0.Row_Addr_Sig = row;  assign vga1.Row_Addr_Sig = row;  assign vga2.Row_Addr_Sig = row;
  assign vga0.rom_data = rom[vga0.rom_addr];
  assign vga1.rom_data = rom[{1'b0, vga1.rom_addr}];
  assign vga2.rom_data = rom[vga2.rom_addr];

  assign rgb_o[0] = {vga0.Red_Sig, vga0.Green_Sig, vga0.Blue_Sig};
  assign rgb_o[1] = {vga1.Red_Sig, vga1.Green_Sig, vga1.Blue_Sig};
  assign rgb_o[2] = {vga2.Red_Sig, vga2.Green_Sig, vga2.Blue_Sig};
  assign addr_o[0] = vga0.rom_addr;
  assign addr_o[1] = {1'b0, vga1.rom_addr};
  assign addr_o[2] = vga2.rom_addr;
  assign cur_o[1]  = {1'b0, cf1};

  vga_sprite_anim_module #(.GLYPH_W(16), .GLYPH_H(16), .NUM_FRAMES(6), .HOLD_FRAMES(2),
                           .SCALE_LOG2(0), .ADDR_W(7)) u_dut0 (
    .vga_clk(vga_clk), .rst(rst), .vga(vga0), .pos_x(pos_x), .pos_y(pos_y),
    .fg_color(fg), .bg_color(bg), .anim_mode(mode), .start(start),
`ifdef SPRITE_MIRROR_EN
    .mirror_h(mirror),
`endif
    .done(done_o[0]), .cur_frame(cur_o[0]));

  vga_sprite_anim_module #(.GLYPH_W(16), .GLYPH_H(16), .NUM_FRAMES(3), .HOLD_FRAMES(1),
                           .SCALE_LOG2(1), .ADDR_W(6)) u_dut1 (
    .vga_clk(vga_clk), .rst(rst), .vga(vga1), .pos_x(pos_x), .pos_y(pos_y),
    .fg_color(fg), .bg_color(bg), .anim_mode(mode), .start(start),
`ifdef SPRITE_MIRROR_EN
    .mirror_h(mirror),
`endif
    .done(done_o[1]), .cur_frame(cf1));

  vga_sprite_anim_module #(.GLYPH_W(16), .GLYPH_H(16), .NUM_FRAMES(6), .HOLD_FRAMES(4),
                           .SCALE_LOG2(0), .ADDR_W(7)) u_dut2 (
    .vga_clk(vga_clk), .rst(rst), .vga(vga2), .pos_x(pos_x), .pos_y(pos_y),
    .fg_color(fg), .bg_color(bg), .anim_mode(mode), .start(start),
`ifdef SPRITE_MIRROR_EN
    .mirror_h(mirror),
`endif
    .done(done_o[2]), .cur_frame(cur_o[2]));

  function automatic int nf(int k);   return (k == 1) ? 3 : 6; endfunction
  function automatic int hold(int k); return (k == 0) ? 2 : ((k == 1) ? 1 : 4); endfunction
  function automatic int sc(int k);   return (k == 1) ? 1 : 0; endfunction

  function automatic int clampc(int v);
    return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
  endfunction

  // frame index from the number of elapsed hold periods, by playback shape
  function automatic int exp_idx(int k);
    int n, steps, p;
    n = nf(k);
    steps = m_frames / hold(k);
    if (!m_running) return 0;
    if (m_mode == 0) return steps % n;
    if (m_mode == 1) begin
      if (n == 1) return 0;
      p = steps % (2 * n - 2);
      return (p < n) ? p : (2 * n - 2 - p);
    end
    return (steps >= n - 1) ? n - 1 : steps;
  endfunction

  function automatic bit exp_done(int k);
    return m_running && (m_mode == 2) && ((m_frames / hold(k)) >= nf(k));
  endfunction

  function automatic bit in_sprite(int k, int c, int r, logic rdy);
    int side;
    side = 16 << sc(k);
    return rdy && (c >= m_px) && (c < m_px + side) && (r >= m_py) && (r < m_py + side);
  endfunction

  function automatic int exp_addr(int k, int c, int r, logic rdy);
    if (!in_sprite(k, c, r, rdy)) return 0;
    return exp_idx(k) * 16 + ((r - m_py) >> sc(k));
  endfunction

  function automatic logic [15:0] exp_rgb(int k, int c, int r, logic rdy);
    logic [15:0] w;
    int gx, b;
    if (!in_sprite(k, c, r, rdy)) return 16'h0000;
    gx = (c - m_px) >> sc(k);
    w  = rom[exp_addr(k, c, r, rdy)];
    b  = m_mir ? gx : 15 - gx;
    return w[b] ? fg : bg;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_frame_state(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_cur%0d", tag, k), 32'(cur_o[k]), 32'(exp_idx(k)));
      chk($sformatf("%s_done%0d", tag, k), 32'(done_o[k]), 32'(exp_done(k)));
    end
  endtask

  // one pixel through the pipeline: address after 1 edge, colour after 2
  task automatic pixel(int c, int r, logic rdy);
    @(negedge vga_clk);
    col = 12'(c); row = 12'(r); ready = rdy;
    @(negedge vga_clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("addr%0d(%0d,%0d)", k, c, r), 32'(addr_o[k]), 32'(exp_addr(k, c, r, rdy)));
    @(negedge vga_clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("rgb%0d(%0d,%0d)", k, c, r), 32'(rgb_o[k]), 32'(exp_rgb(k, c, r, rdy)));
    ready = 1'b0;
  endtask

  task automatic frame_pulse(logic with_start);
    @(negedge vga_clk);
    frame = 1'b1; start = with_start; ready = 1'b0;
    @(negedge vga_clk);
    frame = 1'b0; start = 1'b0;
    m_px = int'(pos_x); m_py = int'(pos_y); m_mir = mirror;
    if (with_start) begin
      m_running = 1'b1; m_frames = 0;
    end else if (m_running && mode != 2'd3) begin
      m_frames++;
    end
    chk_frame_state(with_start ? "frame_start" : "frame");
  endtask

  task automatic do_start(int md, logic with_frame);
    mode = 2'(md); m_mode = md;
    if (with_frame) begin
      frame_pulse(1'b1);
    end else begin
      @(negedge vga_clk); start = 1'b1;
      @(negedge vga_clk); start = 1'b0;
      m_running = 1'b1; m_frames = 0;
      chk_frame_state("start");
    end
  endtask

  task automatic random_pixels(int n);
    for (int i = 0; i < n; i++)
      pixel(clampc(m_px + int'($urandom_range(0, 44)) - 4),
            clampc(m_py + int'($urandom_range(0, 44)) - 4),
            ($urandom_range(0, 7) != 0));
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; ready = 1'b0; frame = 1'b0; start = 1'b0; mirror = 1'b0;
    col = '0; row = '0; pos_x = '0; pos_y = '0; mode = '0;
    fg = 16'hF800; bg = 16'h001F;
    m_frames = 0; m_px = 0; m_py = 0; m_mode = 0; m_running = 1'b0; m_mir = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h8000;

    repeat (3) @(negedge vga_clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rgb%0d", k), 32'(rgb_o[k]), 32'h0);
      chk($sformatf("rst_addr%0d", k), 32'(addr_o[k]), 32'h0);
    end
    chk_frame_state("rst");
    rst = 1'b0;

    // loop
    pos_x = 12'd40; pos_y = 12'd20;
    do_start(0, 1'b0);
    for (int f = 0; f < 13; f++) begin
      frame_pulse(1'b0);
      random_pixels(2);
    end
    // ping-pong
    do_start(1, 1'b0);
    for (int f = 0; f < 9; f++) begin
      frame_pulse(1'b0);
      random_pixels(1);
    end
    // one-shot, then a start coincident with Frame_Sig
    do_start(2, 1'b0);
    for (int f = 0; f < 14; f++) frame_pulse(1'b0);
    do_start(2, 1'b1);
    frame_pulse(1'b0);
    // pause at hold count 1, resume in loop mode
    do_start(0, 1'b0);
    frame_pulse(1'b0);
    mode = 2'd3;
    for (int f = 0; f < 10; f++) frame_pulse(1'b0);
    mode = 2'd0;
    for (int f = 0; f < 3; f++) frame_pulse(1'b0);

    // randomized segments
    for (int s = 0; s < 12; s++) begin
      do_start(int'($urandom_range(0, 2)), ($urandom_range(0, 2) == 0));
      for (int f = 0; f < int'($urandom_range(4, 20)); f++) begin
        pos_x = ($urandom_range(0, 3) == 0) ? 12'(4095 - $urandom_range(0, 20)) : 12'($urandom_range(0, 4095));
        pos_y = ($urandom_range(0, 3) == 0) ? 12'(4095 - $urandom_range(0, 20)) : 12'($urandom_range(0, 4095));
        fg = 16'($urandom); bg = 16'($urandom);
`ifdef SPRITE_MIRROR_EN
        mirror = 1'($urandom);
`endif
        mode = ($urandom_range(0, 4) == 0) ? 2'd3 : 2'(m_mode);
        frame_pulse(1'b0);
        pos_x = 12'($urandom); pos_y = 12'($urandom);
        random_pixels(3);
      end
    end

    // reset in the middle of a lit sprite pixel
    mode = 2'(m_mode); fg = 16'hF800; bg = 16'h001F; mirror = 1'b0;
    @(negedge vga_clk);
    col = 12'(m_px); row = 12'(m_py); ready = 1'b1;
    repeat (2) @(negedge vga_clk);
    #2 rst = 1'b1;
    #1;
    m_running = 1'b0; m_frames = 0; m_px = 0; m_py = 0; m_mir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_rgb%0d", k), 32'(rgb_o[k]), 32'h0);
      chk($sformatf("midrst_addr%0d", k), 32'(addr_o[k]), 32'h0);
    end
    chk_frame_state("midrst");
    @(negedge vga_clk);
    rst = 1'b0; ready = 1'b0;

    // position 0 after reset; 2x2 scaling on instance 1
    pixel(31, 31, 1'b1);
    w = rom[15];
    chk("scale_px31", 32'(rgb_o[1]), 32'(w[0] ? fg : bg));
    pixel(32, 0, 1'b1);
    chk("scale_px32", 32'(rgb_o[1]), 32'h0);
    // new position on the inputs is not used before Frame_Sig
    pos_x = 12'd100; pos_y = 12'd50;
    pixel(0, 0, 1'b1);
    chk("nolatch", 32'(rgb_o[0]), 32'(fg));
    frame_pulse(1'b0);
    pixel(100, 50, 1'b1);
    chk("dir_fg", 32'(rgb_o[0]), 32'(fg));
    pixel(101, 50, 1'b1);
    chk("dir_bg", 32'(rgb_o[0]), 32'(bg));
    pixel(116, 50, 1'b1);
    chk("dir_out", 32'(rgb_o[0]), 32'h0);
    pixel(100, 50, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
